// File: rtl/oai211_bist_pkg.sv
// oai211_bist_pkg: shared types and limits for the oai211 cell self-test sequencer.
package oai211_bist_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;
  localparam int NUM_VEC = 16;
  localparam int VEC_W = 4;
  localparam int FAIL_CNT_W = 8;
  localparam int FAIL_CNT_MAX = 255;
  localparam int CNT_W = 4;
  localparam int SWEEP_W = 5;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int SWEEPS_MIN = 1;
  localparam int SWEEPS_MAX = 31;
endpackage

// File: rtl/oai211_cell_bist_if.sv
// oai211_cell_bist_if: run handshake, cell drive/response and result bundle.
interface oai211_cell_bist_if;
  import oai211_bist_pkg::*;
  logic START;
  logic ABORT;
  logic ZN;
  logic A1;
  logic A2;
  logic B;
  logic C;
  logic BUSY;
  logic DONE;
  logic PASS;
  logic ABORTED;
  logic [FAIL_CNT_W-1:0] FAIL_CNT;
  logic FAIL_VLD;
  logic [VEC_W-1:0] FIRST_FAIL_VEC;
  modport master (
    output START, ABORT, ZN,
    input  A1, A2, B, C, BUSY, DONE, PASS, ABORTED, FAIL_CNT, FAIL_VLD, FIRST_FAIL_VEC
  );
  modport slave (
    input  START, ABORT, ZN,
    output A1, A2, B, C, BUSY, DONE, PASS, ABORTED, FAIL_CNT, FAIL_VLD, FIRST_FAIL_VEC
  );
endinterface

// File: rtl/oai211_golden.sv
// oai211_golden: reference function ZN = ~((A1|A2) & B & C) for a {A1,A2,B,C} vector.
module oai211_golden
  import oai211_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             zn
);
  assign zn = ~((vec[3] | vec[2]) & vec[1] & vec[0]);
endmodule

// File: rtl/oai211_cell_bist.sv
// oai211_cell_bist: sweeps all 16 vectors into an oai211 cell and scores ZN against the golden function.
module oai211_cell_bist
  import oai211_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int SWEEPS = 1
) (
  input logic CLK,
  input logic RN,
  oai211_cell_bist_if.slave io
);
  if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX || SWEEPS < SWEEPS_MIN || SWEEPS > SWEEPS_MAX) begin : g_bad_param
    $error("oai211_cell_bist: SETTLE_CYCLES or SWEEPS out of range");
  end
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  state_t state, state_nxt;
  logic [VEC_W-1:0] vec, vec_nxt, first_fail, first_nxt;
  logic [SWEEP_W-1:0] sweep, sweep_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [FAIL_CNT_W-1:0] fail_cnt, fail_cnt_nxt;
  logic fail_vld, fail_vld_nxt, pass, pass_nxt, aborted, aborted_nxt;
  logic gold_zn, mis, last_vec, last_sweep, abort_hit;
  oai211_golden u_golden (.vec(vec), .zn(gold_zn));
  assign mis = (state == SAMPLE) && (io.ZN != gold_zn);
  assign last_vec = vec == VEC_W'(NUM_VEC - 1);
  assign last_sweep = sweep == SWEEP_W'(SWEEPS - 1);
  assign abort_hit = io.ABORT && (state == SETTLE || state == SAMPLE);
  always_comb begin
    state_nxt = state;
    vec_nxt = vec;
    sweep_nxt = sweep;
    cnt_nxt = cnt;
    fail_cnt_nxt = (mis && fail_cnt != FAIL_CNT_W'(FAIL_CNT_MAX)) ? fail_cnt + 1'b1 : fail_cnt;
    fail_vld_nxt = fail_vld | mis;
    first_nxt = (mis && !fail_vld) ? vec : first_fail;
    pass_nxt = pass;
    aborted_nxt = aborted;
    case (state)
      IDLE: if (io.START) begin
        state_nxt = SETTLE;
        vec_nxt = '0;
        sweep_nxt = '0;
        cnt_nxt = SETTLE_LD;
        fail_cnt_nxt = '0;
        fail_vld_nxt = 1'b0;
        first_nxt = '0;
        pass_nxt = 1'b0;
        aborted_nxt = 1'b0;
      end
      SETTLE: begin
        state_nxt = (cnt == CNT_W'(1)) ? SAMPLE : SETTLE;
        cnt_nxt = cnt - 1'b1;
      end
      SAMPLE: if (last_vec && last_sweep) begin
        state_nxt = FINISH;
        vec_nxt = '0;
        pass_nxt = fail_cnt_nxt == '0;
      end else begin
        state_nxt = SETTLE;
        vec_nxt = vec + 1'b1;
        sweep_nxt = last_vec ? sweep + 1'b1 : sweep;
        cnt_nxt = SETTLE_LD;
      end
      default: state_nxt = IDLE;
    endcase
    // abort overrides sequencing but keeps the mismatch scored in this cycle
    if (abort_hit) begin
      state_nxt = IDLE;
      vec_nxt = '0;
      pass_nxt = 1'b0;
      aborted_nxt = 1'b1;
    end
  end
  always_ff @(posedge CLK or negedge RN)
    if (!RN) begin
      state <= IDLE;
      vec <= '0;
      sweep <= '0;
      cnt <= '0;
      fail_cnt <= '0;
      fail_vld <= 1'b0;
      first_fail <= '0;
      pass <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= state_nxt;
      vec <= vec_nxt;
      sweep <= sweep_nxt;
      cnt <= cnt_nxt;
      fail_cnt <= fail_cnt_nxt;
      fail_vld <= fail_vld_nxt;
      first_fail <= first_nxt;
      pass <= pass_nxt;
      aborted <= aborted_nxt;
    end
  assign {io.A1, io.A2, io.B, io.C} = vec;
  assign io.BUSY = state == SETTLE || state == SAMPLE;
  assign io.DONE = state == FINISH;
  assign io.PASS = pass;
  assign io.ABORTED = aborted;
  assign io.FAIL_CNT = fail_cnt;
  assign io.FAIL_VLD = fail_vld;
  assign io.FIRST_FAIL_VEC = first_fail;
endmodule

// File: tb/tb_oai211_cell_bist.sv
// tb_oai211_cell_bist: five parameter variants against fault-injecting cell models and a cycle-index reference model.
module tb_oai211_cell_bist;
  import oai211_bist_pkg::*;
  localparam int NI = 5;
  localparam int SC_T [NI] = '{2, 2, 1, 15, 1};
  localparam int SW_T [NI] = '{1, 2, 31, 1, 1};
  localparam logic [15:0] GOLD_TBL = 16'h777F;
  logic clk = 1'b0;
  logic rn = 1'b0;
  logic [NI-1:0] start = '0, abort = '0, busy, done, pass_o, abrt, vld;
  logic [7:0] fcnt [NI];
  logic [3:0] first_o [NI], avec [NI];
  int mode [NI] = '{default: 0};
  int checks = 0, passed = 0;
  bit m_busy [NI], m_done [NI], m_pass [NI], m_ab [NI], m_vld [NI];
  int k [NI], m_cnt [NI], m_first [NI];
  int b0, dj, dc;
  always #5 clk = ~clk;
  // cell modes: 0 good, 1 stuck-1, 2 stuck-0, 3 inverted, 4 one-cycle latency, 5 two-cycle latency
  for (genvar g = 0; g < NI; g++) begin : g_dut
    oai211_cell_bist_if io ();
    logic gz;
    logic d1 = 1'b1, d2 = 1'b1;
    oai211_golden u_cell (.vec({io.A1, io.A2, io.B, io.C}), .zn(gz));
    always @(posedge clk) begin
      d1 <= gz;
      d2 <= d1;
    end
    assign io.START = start[g];
    assign io.ABORT = abort[g];
    assign io.ZN = mode[g] == 1 ? 1'b1 : mode[g] == 2 ? 1'b0 : mode[g] == 3 ? ~gz : mode[g] == 4 ? d1 : mode[g] == 5 ? d2 : gz;
    assign busy[g] = io.BUSY;
    assign done[g] = io.DONE;
    assign pass_o[g] = io.PASS;
    assign abrt[g] = io.ABORTED;
    assign vld[g] = io.FAIL_VLD;
    assign fcnt[g] = io.FAIL_CNT;
    assign first_o[g] = io.FIRST_FAIL_VEC;
    assign avec[g] = {io.A1, io.A2, io.B, io.C};
    oai211_cell_bist #(.SETTLE_CYCLES(SC_T[g]), .SWEEPS(SW_T[g])) u_dut (.CLK(clk), .RN(rn), .io(io));
  end
  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, i, $time, act, exp);
  endtask
  function automatic int vec_at(input int i, input int j);
    return j < 0 ? 0 : (j / (SC_T[i] + 1)) % 16;
  endfunction
  function automatic bit cell_zn(input int m, input int v);
    return m == 1 ? 1'b1 : m == 2 ? 1'b0 : m == 3 ? !GOLD_TBL[v] : GOLD_TBL[v];
  endfunction
  function automatic int lat(input int m);
    return m == 4 ? 1 : m == 5 ? 2 : 0;
  endfunction
  // reference: the run is indexed by cycle k since START; vector = k/(SC+1) mod 16, sample on the last cycle of each slot
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (!rn) begin
        m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_ab[i] = 0; m_vld[i] = 0;
        k[i] = 0; m_cnt[i] = 0; m_first[i] = 0;
      end
      chk("busy", i, busy[i], m_busy[i]);
      chk("done", i, done[i], m_done[i]);
      chk("vec", i, avec[i], m_busy[i] ? vec_at(i, k[i]) : 0);
      chk("fail_cnt", i, fcnt[i], m_cnt[i]);
      chk("fail_vld", i, vld[i], m_vld[i]);
      chk("first_fail", i, first_o[i], m_first[i]);
      chk("pass", i, pass_o[i], m_pass[i]);
      chk("aborted", i, abrt[i], m_ab[i]);
      if (rn) begin
        if (m_busy[i]) begin
          if (k[i] % (SC_T[i] + 1) == SC_T[i] && cell_zn(mode[i], vec_at(i, k[i] - lat(mode[i]))) != GOLD_TBL[vec_at(i, k[i])]) begin
            if (m_cnt[i] < 255) m_cnt[i]++;
            if (!m_vld[i]) begin m_vld[i] = 1; m_first[i] = vec_at(i, k[i]); end
          end
          k[i]++;
          if (abort[i]) begin m_busy[i] = 0; m_ab[i] = 1; m_pass[i] = 0; end
          else if (k[i] == 16 * SW_T[i] * (SC_T[i] + 1)) begin m_busy[i] = 0; m_done[i] = 1; m_pass[i] = m_cnt[i] == 0; end
        end else if (m_done[i]) m_done[i] = 0;
        else if (start[i]) begin
          m_busy[i] = 1; m_pass[i] = 0; m_ab[i] = 0; m_vld[i] = 0;
          k[i] = 0; m_cnt[i] = 0; m_first[i] = 0;
        end
      end
    end
  end
  task automatic set_modes(input int m0, input int m1, input int m2, input int m3, input int m4);
    mode = '{m0, m1, m2, m3, m4};
  endtask
  task automatic go(input int ab0, input int rst_j, input bit rnd);
    repeat (4) @(posedge clk);
    #1 start = '1;
    abort = rnd ? NI'($urandom) : '0;
    @(posedge clk);
    #1 start = '0;
    abort = '0;
    b0 = 0; dj = -1; dc = 0;
    for (int j = 0; j < 1000; j++) begin
      if (j == rst_j) begin
        start = '0; abort = '0; rn = 1'b0;
        #1 for (int i = 0; i < NI; i++)
          chk("async_reset", i, {busy[i], done[i], pass_o[i], abrt[i], vld[i], first_o[i], avec[i], fcnt[i]}, 0);
        @(posedge clk);
        #1 rn = 1'b1;
        continue;
      end
      for (int i = 0; i < NI; i++) begin
        start[i] = m_busy[i] && (rnd ? $urandom_range(0, 19) == 0 : (i == 1 && j == 20));
        abort[i] = (i == 0 && ab0 >= 0) ? j == ab0 : rnd && $urandom_range(0, 299) == 0;
      end
      @(negedge clk);
      b0 += int'(busy[0]);
      if (done[0]) begin dc++; dj = j; end
      @(posedge clk);
      #1;
    end
    start = '0;
    abort = '0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rn = 1'b1;
    set_modes(0, 0, 0, 0, 0);
    go(-1, -1, 0);
    chk("run_len", 0, b0, 48);
    chk("done_cycle", 0, dj, 48);
    chk("good_pass", 0, pass_o[0], 1);
    chk("good_cnt", 0, fcnt[0], 0);
    chk("good_vld", 0, vld[0], 0);
    set_modes(1, 1, 1, 1, 1);
    go(-1, -1, 0);
    chk("s1_cnt", 0, fcnt[0], 3);
    chk("s1_first", 0, first_o[0], 7);
    chk("s1_pass", 0, pass_o[0], 0);
    chk("s1_cnt_2sw", 1, fcnt[1], 6);
    chk("s1_first_2sw", 1, first_o[1], 7);
    set_modes(2, 2, 3, 2, 2);
    go(-1, -1, 0);
    chk("s0_cnt", 0, fcnt[0], 13);
    chk("s0_first", 0, first_o[0], 0);
    chk("inv_sat", 2, fcnt[2], 255);
    go(15, -1, 0);
    chk("abort_cnt", 0, fcnt[0], 5);
    chk("abort_flag", 0, abrt[0], 1);
    chk("abort_pass", 0, pass_o[0], 0);
    chk("abort_no_done", 0, dc, 0);
    chk("glitch_pass_cnt", 1, fcnt[1], 26);
    set_modes(0, 0, 0, 0, 0);
    go(-1, 28, 0);
    go(-1, -1, 0);
    chk("rerun_len", 0, b0, 48);
    chk("rerun_done", 0, dj, 48);
    chk("rerun_pass", 0, pass_o[0], 1);
    chk("rerun_cnt", 0, fcnt[0], 0);
    set_modes(5, 0, 0, 5, 4);
    go(-1, -1, 0);
    chk("lat2_sc2_pass", 0, pass_o[0], 1);
    chk("lat2_sc15_pass", 3, pass_o[3], 1);
    chk("lat1_sc1_pass", 4, pass_o[4], 1);
    set_modes(5, 0, 0, 5, 5);
    go(-1, -1, 0);
    chk("lat2_sc1_pass", 4, pass_o[4], 0);
    chk("lat2_sc1_cnt", 4, fcnt[4], 5);
    for (int r = 0; r < 10; r++) begin
      set_modes($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      go(-1, -1, 1);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
